// File: rtl/pll_sequencer_if.sv
// Host/PLL-facing signal bundle of the PLL power-up sequencer.
// The master modport drives the requests and lock; the slave modport is the sequencer.
interface pll_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 6
);
  logic                   enable_i;
  logic                   lock_i;
  logic                   clear_fault_i;
  logic                   pll_pd_n_o;
  logic                   pll_reset_o;
  logic [NUM_DOMAINS-1:0] domain_reset_n_o;
  logic                   ready_o;
  logic                   fault_o;
  logic [7:0]             lock_loss_count_o;

  modport master (
    output enable_i, lock_i, clear_fault_i,
    input  pll_pd_n_o, pll_reset_o, domain_reset_n_o, ready_o, fault_o, lock_loss_count_o
  );

  modport slave (
    input  enable_i, lock_i, clear_fault_i,
    output pll_pd_n_o, pll_reset_o, domain_reset_n_o, ready_o, fault_o, lock_loss_count_o
  );
endinterface

// File: rtl/pll_sequencer.sv
// PLL power-up sequencer: power-down, reset, filtered lock wait with retries,
// then staggered per-domain reset release; every output is a register.
module pll_sequencer #(
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_FILTER  = 64,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned NUM_DOMAINS  = 6,
  parameter int unsigned RELEASE_GAP  = 8
) (
  input logic             clock_i,
  input logic             reset_n_i,
  pll_sequencer_if.slave  bus
);
  localparam int unsigned CNT_MAX_A = (PD_CYCLES > RESET_CYCLES) ? PD_CYCLES : RESET_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > RELEASE_GAP) ? CNT_MAX_A : RELEASE_GAP;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned FLT_W     = $clog2(LOCK_FILTER + 1);
  localparam int unsigned TO_W      = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RTY_W     = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_POWERDOWN, ST_RESET, ST_WAIT_LOCK, ST_RELEASE, ST_RUN, ST_FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic                   lock_meta_q, lock_meta_d;
  logic                   lock_s_q, lock_s_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FLT_W-1:0]       flt_q, flt_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [RTY_W-1:0]       retry_q, retry_d, retry_inc;
  logic [7:0]             loss_q, loss_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d, dom_next;
  logic                   pd_n_q, pd_n_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   lock_lost;

  always_comb begin
    lock_meta_d = bus.lock_i;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    flt_d       = flt_q;
    to_d        = to_q;
    retry_d     = retry_q;
    retry_inc   = retry_q + RTY_W'(1);
    loss_d      = loss_q;
    dom_next    = dom_q;
    lock_lost   = 1'b0;

    unique case (state_q)
      ST_IDLE:      if (bus.enable_i) state_d = ST_POWERDOWN;
      ST_POWERDOWN: if (cnt_q == PD_LAST) state_d = ST_RESET;
      ST_RESET: begin
        flt_d = '0;
        to_d  = '0;
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        flt_d = lock_s_q ? flt_q + FLT_W'(1) : '0;
        to_d  = to_q + TO_W'(1);
        // acceptance is tested first so it wins a same-cycle timeout
        if (lock_s_q && (flt_q == FLT_LAST)) begin
          state_d = ST_RELEASE;
        end else if (to_q == TO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc < RTY_MAX) ? ST_POWERDOWN : ST_FAULT;
        end
      end
      ST_RELEASE: begin
        if (!lock_s_q) begin
          lock_lost = 1'b1;
        end else if (&dom_q) begin
          state_d = ST_RUN;
        end else if (cnt_q == GAP_LAST) begin
          dom_next = (dom_q << 1) | NUM_DOMAINS'(1);
          cnt_d    = '0;
          if (&dom_next) state_d = ST_RUN;
        end
      end
      ST_RUN:   if (!lock_s_q) lock_lost = 1'b1;
      ST_FAULT: if (bus.clear_fault_i) begin
        state_d = ST_IDLE;
        retry_d = '0;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (lock_lost) begin
      state_d = ST_POWERDOWN;
      if (loss_q != '1) loss_d = loss_q + 8'd1;
    end

    // a dropped enable discards any lock-loss or timeout bookkeeping from this cycle
    if (!bus.enable_i && (state_q != ST_FAULT)) begin
      state_d = ST_IDLE;
      loss_d  = loss_q;
      retry_d = retry_q;
    end

    if (state_d != state_q) cnt_d = '0;
    if (state_d == ST_RUN) retry_d = '0;

    pd_n_d    = state_d inside {ST_RESET, ST_WAIT_LOCK, ST_RELEASE, ST_RUN};
    pll_rst_d = state_d inside {ST_IDLE, ST_POWERDOWN, ST_RESET, ST_FAULT};
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);

    if (state_d == ST_RUN)
      dom_d = '1;
    else if (state_d == ST_RELEASE)
      dom_d = (state_q == ST_RELEASE) ? dom_next : NUM_DOMAINS'(1);
    else
      dom_d = '0;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      cnt_q       <= '0;
      flt_q       <= '0;
      to_q        <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      dom_q       <= '0;
      pd_n_q      <= 1'b0;
      pll_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      cnt_q       <= cnt_d;
      flt_q       <= flt_d;
      to_q        <= to_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      dom_q       <= dom_d;
      pd_n_q      <= pd_n_d;
      pll_rst_q   <= pll_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.pll_pd_n_o        = pd_n_q;
  assign bus.pll_reset_o       = pll_rst_q;
  assign bus.domain_reset_n_o  = dom_q;
  assign bus.ready_o           = ready_q;
  assign bus.fault_o           = fault_q;
  assign bus.lock_loss_count_o = loss_q;
endmodule

// File: tb/tb_pll_sequencer.sv
// Bench for pll_sequencer: a per-cycle input plan is randomised up front, a timeline
// model derives every expected output change from it, and a monitor checks the changes.
module tb_pll_sequencer;
  localparam int PD   = 16;
  localparam int RC   = 16;
  localparam int LF   = 64;
  localparam int LT   = 4096;
  localparam int MR   = 3;
  localparam int ND   = 6;
  localparam int GAP  = 8;
  localparam int MAXN = 32768;

  typedef struct packed {
    bit rst;
    bit en;
    bit lk;
    bit clr;
  } drv_t;

  typedef struct {
    int          cyc;
    logic [17:0] val;
  } ev_t;

  drv_t        plan [MAXN];
  ev_t         exp_q [$];
  ev_t         ev;
  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_loss = 8'd0;
  logic [17:0] cur;
  logic [17:0] last_obs = 'x;
  logic [5:0]  dom_obs;
  bit          done = 1'b0;

  pll_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

  pll_sequencer #(
    .PD_CYCLES    (PD),
    .RESET_CYCLES (RC),
    .LOCK_FILTER  (LF),
    .LOCK_TIMEOUT (LT),
    .MAX_RETRIES  (MR),
    .NUM_DOMAINS  (ND),
    .RELEASE_GAP  (GAP)
  ) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(int lo, int hi);
    return lo + int'($urandom_range(32'(hi - lo)));
  endfunction

  // field: 0 reset, 1 enable, 2 lock, 3 clear_fault; edges a..b inclusive
  function automatic void set_rng(int a, int b, int field, bit v);
    for (int i = a; i <= b && i < MAXN; i++) begin
      case (field)
        0:       plan[i].rst = v;
        1:       plan[i].en  = v;
        2:       plan[i].lk  = v;
        default: plan[i].clr = v;
      endcase
    end
  endfunction

  function automatic void exp_at(int c, bit pd, bit rs, logic [5:0] dom, bit rdy, bit flt);
    ev_t e;
    e.cyc = c;
    e.val = {pd, rs, dom, rdy, flt, m_loss};
    exp_q.push_back(e);
  endfunction

  // One attempt whose power-down begins at edge p; returns the edge at which lock is
  // accepted, or -1 when the attempt times out at edge p+PD+RC+LT.
  // The sequencer sees lock_i two edges late through its synchronizer.
  function automatic int attempt(int p);
    int w;
    int run;
    exp_at(p + PD, 1, 1, '0, 0, 0);
    exp_at(p + PD + RC, 1, 0, '0, 0, 0);
    w = p + PD + RC;
    run = 0;
    for (int k = 1; k <= LT; k++) begin
      run = plan[w + k - 2].lk ? run + 1 : 0;
      if (run == LF) return w + k;
    end
    return -1;
  endfunction

  // domain k released GAP*k edges after acceptance edge a; only events before cutoff
  function automatic void rel_events(int a, int cutoff);
    logic [5:0] m;
    m = '0;
    for (int j = 0; j < ND; j++) begin
      m = {m[4:0], 1'b1};
      if (a + GAP * j < cutoff) exp_at(a + GAP * j, 1, 0, m, (j == ND - 1), 0);
    end
  endfunction

  always @(negedge clk) begin
    if (!done) begin
      cur = {bus.pll_pd_n_o, bus.pll_reset_o, bus.domain_reset_n_o, bus.ready_o,
             bus.fault_o, bus.lock_loss_count_o};
      if (cur !== last_obs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.val !== cur) begin
            errors++;
            $display("FAIL output_event cyc=%0d got=%h required=%h at cyc %0d",
                     cyc, cur, ev.val, ev.cyc);
          end
        end
        dom_obs = cur[15:10];
        checks++;
        if (((dom_obs + 6'd1) & dom_obs) != 6'd0 || (cur[16] && dom_obs != 6'd0)) begin
          errors++;
          $display("FAIL release_order cyc=%0d got dom=%b pll_reset=%b required ordered and pll out of reset",
                   cyc, dom_obs, cur[16]);
        end
        last_obs = cur;
      end
    end
  end

  initial begin
    int e, p, a, w, L, d, wd, k, f, r, c, g, R, G, gw, end_cyc;

    // power-on reset
    set_rng(1, 3, 0, 1);
    exp_at(1, 0, 1, '0, 0, 0);

    // first attempt with lock glitching through WAIT_LOCK, then a short lock drop
    e = 6 + rnd(0, 4);
    set_rng(e, MAXN - 1, 1, 1);
    set_rng(6, MAXN - 1, 2, 1);
    w  = e + PD + RC;
    R  = rnd(100, 400);
    G  = rnd(10, 60);
    gw = rnd(1, 3);
    for (int i = w - 2; i < w - 2 + R; i += G) set_rng(i, i + gw - 1, 2, 0);
    a  = attempt(e);
    L  = a + rnd(1, 70);
    d  = L - 2;
    wd = rnd(1, 3);
    set_rng(d, d + wd - 1, 2, 0);
    rel_events(a, L);
    m_loss = m_loss + 8'd1;
    exp_at(L, 0, 1, '0, 0, 0);
    for (int i = 0; i < 4; i++) plan[rnd(e, L + 200)].clr = 1'b1;

    // resequence after the loss; enable drops part-way through release
    a = attempt(L);
    k = rnd(1, 5);
    f = a + GAP * (k - 1) + rnd(1, GAP);
    rel_events(a, f);
    set_rng(f, MAXN - 1, 1, 0);
    if (rnd(0, 1) == 1) plan[f - 2].lk = 1'b0;
    exp_at(f, 0, 1, '0, 0, 0);

    // clean bring-up with lock steady, then synchronous reset while running
    e = f + rnd(2, 6);
    set_rng(e, MAXN - 1, 1, 1);
    a = attempt(e);
    rel_events(a, MAXN);
    r = a + GAP * (ND - 1) + rnd(1, 20);
    set_rng(r, r + 1, 0, 1);
    set_rng(r, MAXN - 1, 1, 0);
    m_loss = 8'd0;
    exp_at(r, 0, 1, '0, 0, 0);

    // lock never arrives: MR timed-out attempts end in FAULT
    set_rng(r, MAXN - 1, 2, 0);
    p = r + 5;
    set_rng(p, MAXN - 1, 1, 1);
    for (int i = 1; i <= MR; i++) begin
      a = attempt(p);
      p = p + PD + RC + LT;
      exp_at(p, 0, 1, '0, 0, (i == MR));
    end
    c = p + rnd(3, 10);
    plan[c].clr = 1'b1;
    exp_at(c, 0, 1, '0, 0, 0);

    // retries were cleared: one timeout returns to POWERDOWN rather than FAULT
    p = c + 1;
    a = attempt(p);
    p = p + PD + RC + LT;
    exp_at(p, 0, 1, '0, 0, 0);

    // lock run completes on the very last WAIT_LOCK cycle: acceptance beats timeout
    w = p + PD + RC;
    set_rng(w + LT - LF - 1, MAXN - 1, 2, 1);
    a = attempt(p);
    rel_events(a, MAXN);
    g = a + GAP * (ND - 1) + rnd(2, 10);
    set_rng(g, MAXN - 1, 1, 0);
    exp_at(g, 0, 1, '0, 0, 0);
    end_cyc = g + 10;

    for (int n = 1; n <= end_cyc; n++) begin
      rst_n             = !plan[n].rst;
      bus.enable_i      = plan[n].en;
      bus.lock_i        = plan[n].lk;
      bus.clear_fault_i = plan[n].clr;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    done = 1'b1;
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event got=no change required=%h at cyc %0d", ev.val, ev.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
